// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared FFT types, default sizes and butterfly address helpers.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int DEF_N_LOG2   = 4;
    localparam int DEF_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } fft_ctrl_state_t;

    typedef logic [DEF_N_LOG2-1:0] addr_t;
    typedef logic [DEF_N_LOG2-2:0] tw_t;

    function automatic int stage_w(input int n_log2);
        return (n_log2 <= 2) ? 1 : $clog2(n_log2);
    endfunction

    function automatic int cnt_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Operand A of butterfly k in stage s: group base plus offset within group.
    function automatic int unsigned bfly_a(input int unsigned s, input int unsigned k);
        int unsigned half;
        half = 32'd1 << s;
        return ((k >> s) << (s + 32'd1)) | (k & (half - 32'd1));
    endfunction

    function automatic int unsigned bfly_tw(input int unsigned s, input int unsigned k,
                                            input int unsigned n_log2);
        return (k & ((32'd1 << s) - 32'd1)) << (n_log2 - 32'd1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : fft_delay_line
// Purpose  : DEPTH-stage shift of {valid, addr_a, addr_b}; clear squashes valids.
// Revision : 1.0
// ============================================================================
module fft_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT,
    parameter int AW    = DEF_N_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [AW-1:0] in_a,
    input  logic [AW-1:0] in_b,
    output logic          out_valid,
    output logic [AW-1:0] out_a,
    output logic [AW-1:0] out_b
);

    logic          vld [DEPTH];
    logic [AW-1:0] a_q [DEPTH];
    logic [AW-1:0] b_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid && !clear;
            a_q[0] <= in_a;
            b_q[0] <= in_b;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1] && !clear;
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_a     = a_q[DEPTH-1];
    assign out_b     = b_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl
// Purpose  : In-place radix-2 DIT FFT sequencer (stages, butterflies, drain gaps).
//            Optional abort input enabled by macro FFT_CTRL_ABORT_EN.
// Revision : 1.0
// ============================================================================
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2   = DEF_N_LOG2,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
`ifdef FFT_CTRL_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [stage_w(N_LOG2)-1:0]  stage,
    output logic                        rd_en,
    output logic [N_LOG2-1:0]           rd_addr_a,
    output logic [N_LOG2-1:0]           rd_addr_b,
    output logic [N_LOG2-2:0]           tw_idx,
    output logic                        wr_en,
    output logic [N_LOG2-1:0]           wr_addr_a,
    output logic [N_LOG2-1:0]           wr_addr_b
);

    localparam int AW = N_LOG2;
    localparam int KW = N_LOG2 - 1;
    localparam int SW = stage_w(N_LOG2);
    localparam int CW = cnt_w(PIPE_LAT);

    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(PIPE_LAT - 1);

    fft_ctrl_state_t state;
    logic [KW-1:0]   k;
    logic [CW-1:0]   wait_cnt;
    logic            abort_hit;

    logic [SW-1:0]   iss_s;
    logic [KW-1:0]   iss_k;
    logic [AW-1:0]   iss_a;
    logic [AW-1:0]   iss_b;
    logic [KW-1:0]   iss_tw;

`ifdef FFT_CTRL_ABORT_EN
    assign abort_hit = abort && (state == RUN || state == DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    // The butterfly issued at the coming edge: first of run, next in stage, or first of next stage.
    always_comb begin
        iss_s = stage;
        iss_k = k + 1'b1;
        if (state == IDLE) begin
            iss_s = '0;
            iss_k = '0;
        end else if (state == DRAIN) begin
            iss_s = stage + 1'b1;
            iss_k = '0;
        end
    end

    assign iss_a  = AW'(bfly_a(32'(iss_s), 32'(iss_k)));
    assign iss_b  = iss_a + AW'(32'd1 << iss_s);
    assign iss_tw = KW'(bfly_tw(32'(iss_s), 32'(iss_k), N_LOG2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else if (abort_hit) begin
            state    <= IDLE;
            stage    <= '0;
            k        <= '0;
            wait_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        stage     <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr_a <= iss_a;
                        rd_addr_b <= iss_b;
                        tw_idx    <= iss_tw;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state    <= DRAIN;
                        wait_cnt <= '0;
                        rd_en    <= 1'b0;
                    end else begin
                        k         <= iss_k;
                        rd_en     <= 1'b1;
                        rd_addr_a <= iss_a;
                        rd_addr_b <= iss_b;
                        tw_idx    <= iss_tw;
                    end
                end
                DRAIN: begin
                    if (wait_cnt != C_LAST) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else if (stage == S_LAST) begin
                        state <= FIN;
                        stage <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        stage     <= iss_s;
                        k         <= '0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= iss_a;
                        rd_addr_b <= iss_b;
                        tw_idx    <= iss_tw;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fft_delay_line #(
        .DEPTH (PIPE_LAT),
        .AW    (AW)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort_hit),
        .in_valid  (rd_en),
        .in_a      (rd_addr_a),
        .in_b      (rd_addr_b),
        .out_valid (wr_en),
        .out_a     (wr_addr_a),
        .out_b     (wr_addr_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft_ctrl
// Purpose  : Directed self-checking bench for fft_ctrl (FFT_CTRL_ABORT_EN optional).
// Revision : 1.0
// ============================================================================
module tb_fft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start_x;
`ifdef FFT_CTRL_ABORT_EN
    logic abort;
`endif

    int passed = 0;
    int total  = 0;

    // Default build: N_LOG2=4, PIPE_LAT=2
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [3:0] ra, rb, wa, wb;
    logic [2:0] tw;

    fft_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT_CTRL_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
        .rd_addr_a(ra), .rd_addr_b(rb), .tw_idx(tw),
        .wr_en(wr_en), .wr_addr_a(wa), .wr_addr_b(wb)
    );

    // N_LOG2=3, PIPE_LAT=2
    logic       busy3, done3, rd3, wr3;
    logic [1:0] stage3, tw3;
    logic [2:0] ra3, rb3, wa3, wb3;

    fft_ctrl #(.N_LOG2(3), .PIPE_LAT(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_x),
`ifdef FFT_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy3), .done(done3), .stage(stage3), .rd_en(rd3),
        .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_idx(tw3),
        .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3)
    );

    // PIPE_LAT=1 and PIPE_LAT=8, N_LOG2=4
    logic       busy1, done1, rd1, wr1, busy8, done8, rd8, wr8;
    logic [1:0] stage1, stage8;
    logic [3:0] ra1, rb1, wa1, wb1, ra8, rb8, wa8, wb8;
    logic [2:0] tw1, tw8;

    fft_ctrl #(.N_LOG2(4), .PIPE_LAT(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .start(start_x),
`ifdef FFT_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_idx(tw1),
        .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    fft_ctrl #(.N_LOG2(4), .PIPE_LAT(8)) dut_p8 (
        .clk(clk), .rst_n(rst_n), .start(start_x),
`ifdef FFT_CTRL_ABORT_EN
        .abort(1'b0),
`endif
        .busy(busy8), .done(done8), .stage(stage8), .rd_en(rd8),
        .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_idx(tw8),
        .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8)
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_x = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, rd_en, wr_en, stage} !== 6'd0)
            $display("FAIL reset_ctrl got %b want 0", {busy, done, rd_en, wr_en, stage});
        else passed++;
        total++;
        if ({ra, rb, tw, wa, wb} !== 19'd0)
            $display("FAIL reset_addr got %h want 0", {ra, rb, tw, wa, wb});
        else passed++;
        total++;
        if ({busy3, done3, rd3, wr3, busy1, rd1, busy8, rd8} !== 8'd0)
            $display("FAIL reset_variants got %b want 0", {busy3, done3, rd3, wr3, busy1, rd1, busy8, rd8});
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stage_addr_n3();
        int ea [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int eb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int et [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int j = 0, wj = 0;
        @(negedge clk); start_x = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            start_x = 1'b0;
            if (rd3) begin
                total++;
                if (j >= 12)
                    $display("FAIL n3_extra_read got %0d want 12", j + 1);
                else if ({stage3, ra3, rb3, tw3} !== {2'(j / 4), 3'(ea[j]), 3'(eb[j]), 2'(et[j])})
                    $display("FAIL n3_read[%0d] got s%0d (%0d,%0d) t%0d want s%0d (%0d,%0d) t%0d",
                             j, stage3, ra3, rb3, tw3, j / 4, ea[j], eb[j], et[j]);
                else passed++;
                j++;
            end
            if (wr3) begin
                total++;
                if (wj >= 12)
                    $display("FAIL n3_extra_write got %0d want 12", wj + 1);
                else if ({wa3, wb3} !== {3'(ea[wj]), 3'(eb[wj])})
                    $display("FAIL n3_write[%0d] got (%0d,%0d) want (%0d,%0d)", wj, wa3, wb3, ea[wj], eb[wj]);
                else passed++;
                wj++;
            end
            total++;
            if ({done3, busy3} !== {c == 19, c <= 18})
                $display("FAIL n3_done_busy c%0d got %b want %b", c, {done3, busy3}, {c == 19, c <= 18});
            else passed++;
        end
        total++;
        if (j != 12 || wj != 12)
            $display("FAIL n3_counts got %0d/%0d want 12/12", j, wj);
        else passed++;
    endtask

    task automatic test_timing_and_restart();
        logic [8:0] hist [0:127];
        logic [2:0] exp;
        int cr, wr_cnt;
        wr_cnt = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 84; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 41 || c == 42);
            cr  = (c <= 42) ? c : c - 42;
            exp = {cr <= 40, cr == 41, (cr <= 40) && ((cr - 1) % 10 < 8)};
            total++;
            if ({busy, done, rd_en} !== exp)
                $display("FAIL timing c%0d busy/done/rd got %b want %b", c, {busy, done, rd_en}, exp);
            else passed++;
            hist[c] = {rd_en, ra, rb};
            total++;
            if (c >= 3) begin
                if ({wr_en, wa, wb} !== hist[c-2])
                    $display("FAIL writeback c%0d got %h want %h", c, {wr_en, wa, wb}, hist[c-2]);
                else passed++;
            end else begin
                if (wr_en !== 1'b0)
                    $display("FAIL early_write c%0d got %b want 0", c, wr_en);
                else passed++;
            end
            if (wr_en) wr_cnt++;
            if (c == 43) begin
                total++;
                if ({stage, ra, rb, tw} !== {2'd0, 4'd0, 4'd1, 3'd0})
                    $display("FAIL restart_first got %h want %h", {stage, ra, rb, tw}, {2'd0, 4'd0, 4'd1, 3'd0});
                else passed++;
            end
        end
        total++;
        if (wr_cnt != 64)
            $display("FAIL write_count got %0d want 64", wr_cnt);
        else passed++;
    endtask

    task automatic test_hazard();
        int cnt1 [16];
        int cnt8 [16];
        int sum1 = 0, sum8 = 0;
        for (int i = 0; i < 16; i++) begin cnt1[i] = 0; cnt8[i] = 0; end
        @(negedge clk); start_x = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start_x = 1'b0;
            if (rd1) begin
                total++;
                if (cnt1[ra1] != int'(stage1) || cnt1[rb1] != int'(stage1))
                    $display("FAIL hazard_p1 c%0d got %0d/%0d want %0d", c, cnt1[ra1], cnt1[rb1], stage1);
                else passed++;
            end
            if (rd8) begin
                total++;
                if (cnt8[ra8] != int'(stage8) || cnt8[rb8] != int'(stage8))
                    $display("FAIL hazard_p8 c%0d got %0d/%0d want %0d", c, cnt8[ra8], cnt8[rb8], stage8);
                else passed++;
            end
            if (wr1) begin cnt1[wa1]++; cnt1[wb1]++; end
            if (wr8) begin cnt8[wa8]++; cnt8[wb8]++; end
            if (c == 37 || c == 65) begin
                total++;
                if ({done1, done8} !== {c == 37, c == 65})
                    $display("FAIL done_p1_p8 c%0d got %b want %b", c, {done1, done8}, {c == 37, c == 65});
                else passed++;
            end
        end
        for (int i = 0; i < 16; i++) begin sum1 += cnt1[i]; sum8 += cnt8[i]; end
        total++;
        if (sum1 != 64 || sum8 != 64)
            $display("FAIL hazard_writes got %0d/%0d want 64/64", sum1, sum8);
        else passed++;
        total++;
        if ({busy1, ra1, rb1, tw1, busy8, ra8, rb8, tw8} !== {1'b0, 4'd7, 4'd15, 3'd7, 1'b0, 4'd7, 4'd15, 3'd7})
            $display("FAIL hold_last got %h want %h", {busy1, ra1, rb1, tw1, busy8, ra8, rb8, tw8},
                     {1'b0, 4'd7, 4'd15, 3'd7, 1'b0, 4'd7, 4'd15, 3'd7});
        else passed++;
    endtask

    task automatic test_reset_midrun();
        int bad = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({busy, rd_en, stage} !== 4'b1101)
            $display("FAIL midrun_before got %b want 1101", {busy, rd_en, stage});
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, rd_en, wr_en, stage, ra, rb, tw, wa, wb} !== 25'd0)
            $display("FAIL midrun_async_reset got %h want 0", {busy, done, rd_en, wr_en, stage, ra, rb, tw, wa, wb});
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_en || busy) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL post_reset_quiet got %0d want 0", bad);
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({rd_en, stage, ra, rb, tw} !== {1'b1, 2'd0, 4'd0, 4'd1, 3'd0})
            $display("FAIL post_reset_restart got %h want %h", {rd_en, stage, ra, rb, tw},
                     {1'b1, 2'd0, 4'd0, 4'd1, 3'd0});
        else passed++;
        for (int c = 2; c <= 41; c++) begin
            @(negedge clk);
            if (c == 41) begin
                total++;
                if (done !== 1'b1)
                    $display("FAIL post_reset_done got %b want 1", done);
                else passed++;
            end
        end
    endtask

`ifdef FFT_CTRL_ABORT_EN
    task automatic test_abort();
        int bad = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 88; c++) begin
            @(negedge clk);
            start = (c == 46);
            abort = (c == 9 || c == 46);
            if (c == 9) begin
                total++;
                if ({busy, rd_en, wr_en} !== 3'b101)
                    $display("FAIL abort_drain_state got %b want 101", {busy, rd_en, wr_en});
                else passed++;
            end
            if (c == 10) begin
                total++;
                if ({busy, rd_en} !== 2'b00)
                    $display("FAIL abort_idle got %b want 00", {busy, rd_en});
                else passed++;
            end
            if (c >= 10 && c <= 46 && (wr_en || done)) bad++;
            if (c == 47) begin
                total++;
                if ({busy, rd_en, ra, rb} !== {2'b11, 4'd0, 4'd1})
                    $display("FAIL start_beats_abort got %h want %h", {busy, rd_en, ra, rb}, {2'b11, 4'd0, 4'd1});
                else passed++;
            end
            if (c == 87) begin
                total++;
                if (done !== 1'b1)
                    $display("FAIL abort_rerun_done got %b want 1", done);
                else passed++;
            end
        end
        total++;
        if (bad != 0)
            $display("FAIL abort_squash got %0d want 0", bad);
        else passed++;
    endtask
`endif

    initial begin
`ifdef FFT_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_stage_addr_n3();
        test_timing_and_restart();
        test_hazard();
        test_reset_midrun();
`ifdef FFT_CTRL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
